// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the single-step / run controller: state type and counter widths.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2
    } step_state_t;

    localparam int CNT_W      = 24;
    localparam int STEP_CNT_W = 16;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level debounce and one-cycle press pulse.
module btn_debounce
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             db_state_r;
    logic             db_prev_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronize, count consecutive differing samples, accept the level and flag rising edges
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            db_state_r <= 1'b0;
            db_prev_r  <= 1'b0;
            press_r    <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            if (sync2_r == db_state_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_MAX) begin
                db_state_r <= sync2_r;
                cnt_r      <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            db_prev_r <= db_state_r;
            press_r   <= db_state_r & ~db_prev_r;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/step_ctrl.sv
// CPU clock-enable controller: HALT / STEP / RUN sequencing from two debounced buttons,
// with a RUN-mode enable divider and a count of issued enables.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RUN_DIV         = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_step,
    input  logic                  btn_mode,
    output logic                  cpu_en,
    output logic                  mode_run,
    output logic [STEP_CNT_W-1:0] step_count
);

    localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(RUN_DIV - 1);

    logic                  step_press_s;
    logic                  mode_press_s;
    step_state_t           state_r;
    step_state_t           state_next_s;
    logic [CNT_W-1:0]      div_r;
    logic [CNT_W-1:0]      div_next_s;
    logic                  cpu_en_r;
    logic                  cpu_en_next_s;
    logic                  mode_run_r;
    logic [STEP_CNT_W-1:0] step_count_r;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_step),
        .press (step_press_s)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_mode),
        .press (mode_press_s)
    );

    // Next state, divider advance and enable decode; a mode press outranks a step press in HALT
    always_comb begin
        state_next_s  = state_r;
        div_next_s    = {CNT_W{1'b0}};
        cpu_en_next_s = 1'b0;
        case (state_r)
            HALT: begin
                if (mode_press_s) begin
                    state_next_s = RUN;
                end else if (step_press_s) begin
                    state_next_s = STEP;
                end else begin
                    state_next_s = HALT;
                end
            end
            STEP: state_next_s = HALT;
            RUN: begin
                if (mode_press_s) begin
                    state_next_s = HALT;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = HALT;
        endcase

        // The divider restarts from zero on every RUN entry and is dropped on exit
        if ((state_r == RUN) && (state_next_s == RUN)) begin
            if (div_r == DIV_MAX) begin
                div_next_s = {CNT_W{1'b0}};
            end else begin
                div_next_s = div_r + CNT_W'(1);
            end
        end else begin
            div_next_s = {CNT_W{1'b0}};
        end

        if (state_next_s == STEP) begin
            cpu_en_next_s = 1'b1;
        end else if ((state_next_s == RUN) && (div_next_s == DIV_MAX)) begin
            cpu_en_next_s = 1'b1;
        end else begin
            cpu_en_next_s = 1'b0;
        end
    end

    // State, divider and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= HALT;
            div_r        <= {CNT_W{1'b0}};
            cpu_en_r     <= 1'b0;
            mode_run_r   <= 1'b0;
            step_count_r <= {STEP_CNT_W{1'b0}};
        end else begin
            state_r    <= state_next_s;
            div_r      <= div_next_s;
            cpu_en_r   <= cpu_en_next_s;
            mode_run_r <= (state_next_s == RUN);
            if (cpu_en_next_s) begin
                step_count_r <= step_count_r + STEP_CNT_W'(1);
            end else begin
                step_count_r <= step_count_r;
            end
        end
    end

    assign cpu_en     = cpu_en_r;
    assign mode_run   = mode_run_r;
    assign step_count = step_count_r;

endmodule
